// File: rtl/alu_flags.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flags
//  Brief    : SM83 flag register (Z N H C) downstream of the ALU, two-pass
//             16-bit add sequencer, result register and branch conditions.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flags (
    input  logic       CLK2,
    input  logic       RESET,
    input  logic       op_valid,
    input  logic [3:0] op_class,
    input  logic       sp_rel,
    input  logic [7:0] res,
    input  logic       cy3,
    input  logic       cy7,
    input  logic       f_load_en,
    input  logic [7:0] f_load,
    input  logic [1:0] cc_sel,
    output logic [7:0] F,
    output logic       carry_in,
    output logic       cc_true,
    output logic [7:0] res_q,
    output logic       res_valid,
    output logic       busy16
);

    localparam logic [3:0] c_OP_NOP     = 4'd0;
    localparam logic [3:0] c_OP_ADD     = 4'd1;
    localparam logic [3:0] c_OP_SUB     = 4'd2;
    localparam logic [3:0] c_OP_AND     = 4'd3;
    localparam logic [3:0] c_OP_OR      = 4'd4;
    localparam logic [3:0] c_OP_INC     = 4'd5;
    localparam logic [3:0] c_OP_DEC     = 4'd6;
    localparam logic [3:0] c_OP_ROTA    = 4'd7;
    localparam logic [3:0] c_OP_CB      = 4'd8;
    localparam logic [3:0] c_OP_BIT     = 4'd9;
    localparam logic [3:0] c_OP_DAA     = 4'd10;
    localparam logic [3:0] c_OP_CPL     = 4'd11;
    localparam logic [3:0] c_OP_SCF     = 4'd12;
    localparam logic [3:0] c_OP_CCF     = 4'd13;
    localparam logic [3:0] c_OP_ADD16LO = 4'd14;
    localparam logic [3:0] c_OP_ADD16HI = 4'd15;

    localparam logic [0:0] c_ST_IDLE       = 1'b0;
    localparam logic [0:0] c_ST_HI_PENDING = 1'b1;

    localparam logic [1:0] c_CC_NZ = 2'd0;
    localparam logic [1:0] c_CC_Z  = 2'd1;
    localparam logic [1:0] c_CC_NC = 2'd2;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_wc;
    logic       w_wc_nxt;
    logic       r_z, r_n, r_h, r_c;
    logic       w_z_nxt, w_n_nxt, w_h_nxt, w_c_nxt;
    logic       w_zero;
    logic       w_op_take;
    logic [7:0] r_res_q;
    logic       r_res_valid;
    logic       w_unused_f_load_low;

    // Low nibble of a popped F is hardwired to zero in the flag register.
    assign w_unused_f_load_low = &{1'b0, f_load[3:0]};

    // A simultaneous POP AF wins and the ALU op is dropped entirely.
    assign w_op_take = op_valid & ~f_load_en;
    assign w_zero    = (res == 8'h00);

    // Flag update rules; unlisted flags hold.
    always_comb begin
        w_z_nxt = r_z;
        w_n_nxt = r_n;
        w_h_nxt = r_h;
        w_c_nxt = r_c;
        case (op_class)
            c_OP_NOP: ;
            c_OP_ADD: begin
                w_z_nxt = w_zero & ~sp_rel;
                w_n_nxt = 1'b0;
                w_h_nxt = cy3;
                w_c_nxt = cy7;
            end
            c_OP_SUB: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b1;
                w_h_nxt = cy3;
                w_c_nxt = cy7;
            end
            c_OP_AND: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b1;
                w_c_nxt = 1'b0;
            end
            c_OP_OR: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b0;
                w_c_nxt = 1'b0;
            end
            c_OP_INC: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b0;
                w_h_nxt = cy3;
            end
            c_OP_DEC: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b1;
                w_h_nxt = cy3;
            end
            c_OP_ROTA: begin
                w_z_nxt = 1'b0;
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b0;
                w_c_nxt = cy7;
            end
            c_OP_CB: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b0;
                w_c_nxt = cy7;
            end
            c_OP_BIT: begin
                w_z_nxt = w_zero;
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b1;
            end
            c_OP_DAA: begin
                w_z_nxt = w_zero;
                w_h_nxt = 1'b0;
                w_c_nxt = r_c | cy7;
            end
            c_OP_CPL: begin
                w_n_nxt = 1'b1;
                w_h_nxt = 1'b1;
            end
            c_OP_SCF: begin
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b0;
                w_c_nxt = 1'b1;
            end
            c_OP_CCF: begin
                w_n_nxt = 1'b0;
                w_h_nxt = 1'b0;
                w_c_nxt = ~r_c;
            end
            c_OP_ADD16LO: ;
            c_OP_ADD16HI: begin
                w_n_nxt = 1'b0;
                w_h_nxt = cy3;
                w_c_nxt = cy7;
            end
            default: ;
        endcase
    end

    // Next-state: only a low pass parks the sequencer; anything else drops wc.
    always_comb begin
        w_state_nxt = r_state;
        w_wc_nxt    = r_wc;
        if (f_load_en) begin
            w_state_nxt = c_ST_IDLE;
            w_wc_nxt    = 1'b0;
        end else if (op_valid) begin
            if (op_class == c_OP_ADD16LO) begin
                w_state_nxt = c_ST_HI_PENDING;
                w_wc_nxt    = cy7;
            end else begin
                w_state_nxt = c_ST_IDLE;
                w_wc_nxt    = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            r_state     <= c_ST_IDLE;
            r_wc        <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_h         <= 1'b0;
            r_c         <= 1'b0;
            r_res_q     <= 8'h00;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wc        <= w_wc_nxt;
            r_res_valid <= w_op_take;
            if (f_load_en) begin
                r_z <= f_load[7];
                r_n <= f_load[6];
                r_h <= f_load[5];
                r_c <= f_load[4];
            end else if (op_valid) begin
                r_z     <= w_z_nxt;
                r_n     <= w_n_nxt;
                r_h     <= w_h_nxt;
                r_c     <= w_c_nxt;
                r_res_q <= res;
            end
        end
    end

    // An orphan high pass in IDLE must not inherit F.C as its carry.
    always_comb begin
        if (r_state == c_ST_HI_PENDING)
            carry_in = r_wc;
        else if (op_valid && (op_class == c_OP_ADD16HI))
            carry_in = 1'b0;
        else
            carry_in = r_c;
    end

    always_comb begin
        case (cc_sel)
            c_CC_NZ: cc_true = ~r_z;
            c_CC_Z:  cc_true = r_z;
            c_CC_NC: cc_true = ~r_c;
            default: cc_true = r_c;
        endcase
    end

    assign F         = {r_z, r_n, r_h, r_c, 4'b0000};
    assign res_q     = r_res_q;
    assign res_valid = r_res_valid;
    assign busy16    = (r_state == c_ST_HI_PENDING);

endmodule
`default_nettype wire

// File: doc/alu_flags.md
# alu_flags

Flag-register stage directly downstream of the ALU in the SM83 core. It consumes the ALU result byte and the bit-3/bit-7 carries, updates the F register (Z N H C), and sequences the two-pass 16-bit add. It also returns the carry-in the ALU needs on its next operation, registers the result for writeback, and evaluates branch conditions.

## Interface
No parameters.
- CLK2  in  1  core clock; every register updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- op_valid  in  1  one-cycle strobe: res/cy3/cy7/op_class are valid this cycle
- op_class  in  4  flag rule selector (see Operation)
- sp_rel  in  1  with op_class=1: ADD SP,e8 / LD HL,SP+e8, forces Z=0
- res  in  8  ALU result byte
- cy3  in  1  carry/borrow out of bit 3
- cy7  in  1  carry/borrow out of bit 7 (the shifted-out bit for rotates)
- f_load_en  in  1  POP AF load strobe
- f_load  in  8  byte popped into F
- cc_sel  in  2  condition: 0 NZ, 1 Z, 2 NC, 3 C
- F  out  8  {Z,N,H,C,4'b0}
- carry_in  out  1  carry presented to the ALU
- cc_true  out  1  condition result (combinational from F)
- res_q  out  8  registered result
- res_valid  out  1  one-cycle pulse, res_q is new
- busy16  out  1  high while in HI_PENDING

## Operation
- Z' = (res==0). All unlisted flags keep their value.
- 0 NOP: no change.
- 1 ADD/ADC: Z', N0, H=cy3, C=cy7. If sp_rel=1 then Z=0.
- 2 SUB/SBC/CP: Z', N1, H=cy3, C=cy7.
- 3 AND: Z', N0, H1, C0.
- 4 OR/XOR: Z', N0, H0, C0.
- 5 INC: Z', N0, H=cy3.
- 6 DEC: Z', N1, H=cy3.
- 7 RLCA/RRCA/RLA/RRA: Z0, N0, H0, C=cy7.
- 8 CB rotate/shift/SWAP: Z', N0, H0, C=cy7.
- 9 BIT: Z', N0, H1. res is the masked bit.
- 10 DAA: Z', H0, C=C|cy7.
- 11 CPL: N1, H1.
- 12 SCF: N0, H0, C1.
- 13 CCF: N0, H0, C=~C.
- 14 ADD16_LO: F unchanged. Latch cy7 into wc. Go to HI_PENDING.
- 15 ADD16_HI: N0, H=cy3, C=cy7, Z kept. Go to IDLE.
- F[3:0] is always 0.
- State machine has two states, IDLE and HI_PENDING. Transitions:
  - IDLE, op 14 -> HI_PENDING.
  - HI_PENDING, op 15 -> IDLE.
  - HI_PENDING, any other op (including another 14) -> that op is applied normally. For 14, wc is re-latched and the state stays HI_PENDING. For all others, the state goes to IDLE and wc is discarded.
  - IDLE, op 15 -> applied normally with carry_in=0 (orphan high pass); state stays IDLE.
  - HI_PENDING with no op_valid: the state holds indefinitely.
- carry_in = wc in HI_PENDING, 0 for an orphan op 15 in IDLE, otherwise F.C.
- f_load_en: F <= {f_load[7:4],4'b0}. It takes priority over a simultaneous op_valid; that op is dropped (no F change, no res_valid). State goes to IDLE.
- cc_true: NZ=~Z, Z=Z, NC=~C, C=C. Computed from the current F, not the in-flight update.
- res_q captures res on every op_valid (all classes, including NOP) unless the op is dropped by f_load_en.

## Timing
- Reset values: F=0x00, state IDLE, wc=0, res_q=0x00, res_valid=0, busy16=0. Outputs derived from these: carry_in=0, cc_true=1 when cc_sel=NZ or NC.
- RESET dominates all inputs. Asserting it mid-HI_PENDING aborts the 16-bit add.
- Latency from an op_valid edge:
  - F, res_q and state update at that edge and are visible the following cycle.
  - res_valid is high for exactly that following cycle.
- Back-to-back op_valid every cycle is supported. Each op sees the F written by its predecessor.
- carry_in and busy16 are combinational from registered state, so they are stable for the whole cycle.

## Test plan
- Reset -> F=0x00, res_q=0x00, res_valid=0, busy16=0. With cc_sel=0 (NZ), cc_true=1.
- op 1, res=0x00, cy3=1, cy7=1 -> F=0xB0 next cycle; res_valid pulses once. Repeat with sp_rel=1 -> F=0x30.
- From F=0x10: op 5, res=0x00, cy3=1 -> F=0xB0 (C kept). Then op 13 -> F=0x80.
- 16-bit add:
  - From F=0x80: op 14 with cy7=1 -> F stays 0x80, busy16=1, carry_in=1.
  - Then op 15 with cy3=0, cy7=1 -> F=0x90, busy16=0.
  - Repeat, but send op 3 instead of op 15 -> state goes to IDLE and AND flags are applied.
- Same cycle: f_load_en with f_load=0xFF and op_valid with op 12 -> F=0xF0, res_valid=0, state IDLE. Then cc_sel=3 -> cc_true=1.
- Enter HI_PENDING, then assert RESET for one cycle -> busy16=0, F=0x00, carry_in=0. Then op 15 -> applied as orphan with carry_in=0, state stays IDLE.
